apple_spawn_ctrl: RTL and testbench



---
 rtl/apple_spawn_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_apple_spawn_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_spawn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawn_ctrl
//  Purpose  : Owns the snake apple. Detects head/apple collision, pulses a
//             grow request, keeps a saturating score and respawns the apple
//             at a pseudo-random in-bounds cell that is not under the body.
//             The body is scanned through a RAM read port with one cycle of
//             read latency, and a fresh candidate is drawn after any hit.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_50MHz      system clock
//    rst_n          synchronous active-low reset
//    mode_i         0 = menu, 1 = play, 2/3 = game over
//    head_x_i/_y_i  snake head cell
//    snake_len_i    segment count including head (0 is treated as 1)
//    seg_addr_o     body RAM read address (index 0 = head)
//    seg_x_i/_y_i   body RAM data, valid the cycle after seg_addr_o
//    apple_x_o/_y_o apple cell
//    apple_valid_o  apple placed; the renderer draws it only when high
//    apple_eaten_o  one-cycle pulse per eat; movement grows the snake
//    busy_o         respawn in progress; movement stalls while high
//    score_o        apples eaten, saturating at 255
// ============================================================================
module apple_spawn_ctrl #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 64,
    parameter int DEF_X   = 25,
    parameter int DEF_Y   = 15
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic [1:0] mode_i,
    input  logic [5:0] head_x_i,
    input  logic [5:0] head_y_i,
    input  logic [6:0] snake_len_i,
    output logic [5:0] seg_addr_o,
    input  logic [5:0] seg_x_i,
    input  logic [5:0] seg_y_i,
    output logic [5:0] apple_x_o,
    output logic [5:0] apple_y_o,
    output logic       apple_valid_o,
    output logic       apple_eaten_o,
    output logic       busy_o,
    output logic [7:0] score_o
);

    localparam logic [5:0]  c_SPAN_X    = 6'(GRID_W - 2);
    localparam logic [5:0]  c_SPAN_Y    = 6'(GRID_H - 2);
    localparam logic [5:0]  c_DEF_X     = 6'(DEF_X);
    localparam logic [5:0]  c_DEF_Y     = 6'(DEF_Y);
    localparam logic [6:0]  c_MAX_LEN   = 7'(MAX_LEN);
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_GEN    = 3'd2,
        S_SCAN   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  apple_x_q, apple_x_d;
    logic [5:0]  apple_y_q, apple_y_d;
    logic        apple_valid_q, apple_valid_d;
    logic        eaten_q, eaten_d;
    logic [7:0]  score_q, score_d;
    logic [5:0]  seg_addr_q, seg_addr_d;
    logic [5:0]  cand_x_q, cand_x_d;
    logic [5:0]  cand_y_q, cand_y_d;
    logic [6:0]  len_q, len_d;
    // cmp_vld: a read was issued last cycle, so seg_x/seg_y hold its data.
    // cmp_last: that read was the final body index.
    logic        cmp_vld_q, cmp_vld_d;
    logic        cmp_last_q, cmp_last_d;

    logic        w_match;
    logic        w_last_issue;
    logic [6:0]  w_len;

    // Fold 0..63 into 0..span-1 with two conditional subtractions, then
    // shift into 1..span so the border cells are never chosen.
    function automatic logic [5:0] f_wrap(input logic [5:0] v, input logic [5:0] span);
        logic [5:0] r;
        r = v;
        if (r >= span) r = r - span;
        if (r >= span) r = r - span;
        return r + 6'd1;
    endfunction

    assign w_match      = (seg_x_i == cand_x_q) && (seg_y_i == cand_y_q);
    assign w_last_issue = ({1'b0, seg_addr_q} == (len_q - 7'd1));
    assign w_len        = (snake_len_i == 7'd0)     ? 7'd1 :
                          (snake_len_i > c_MAX_LEN) ? c_MAX_LEN : snake_len_i;

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= c_LFSR_SEED;
            apple_x_q     <= c_DEF_X;
            apple_y_q     <= c_DEF_Y;
            apple_valid_q <= 1'b1;
            eaten_q       <= 1'b0;
            score_q       <= 8'd0;
            seg_addr_q    <= 6'd0;
            cand_x_q      <= 6'd0;
            cand_y_q      <= 6'd0;
            len_q         <= 7'd1;
            cmp_vld_q     <= 1'b0;
            cmp_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            eaten_q       <= eaten_d;
            score_q       <= score_d;
            seg_addr_q    <= seg_addr_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            len_q         <= len_d;
            cmp_vld_q     <= cmp_vld_d;
            cmp_last_q    <= cmp_last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10; free-running.
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        eaten_d       = 1'b0;
        score_d       = score_q;
        seg_addr_d    = seg_addr_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        len_d         = len_q;
        cmp_vld_d     = 1'b0;
        cmp_last_d    = cmp_last_q;

        if (state_q == S_IDLE) begin
            apple_x_d     = c_DEF_X;
            apple_y_d     = c_DEF_Y;
            apple_valid_d = 1'b1;
            if (mode_i == 2'd0) score_d = 8'd0;
            if (mode_i == 2'd1) state_d = S_PLAY;
        end else if (mode_i != 2'd1) begin
            // Leaving play abandons any respawn and parks the apple.
            state_d       = S_IDLE;
            apple_x_d     = c_DEF_X;
            apple_y_d     = c_DEF_Y;
            apple_valid_d = 1'b1;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (apple_valid_q && (head_x_i == apple_x_q) && (head_y_i == apple_y_q)) begin
                        eaten_d       = 1'b1;
                        apple_valid_d = 1'b0;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        state_d       = S_GEN;
                    end
                end
                S_GEN: begin
                    cand_x_d   = f_wrap(lfsr_q[5:0], c_SPAN_X);
                    cand_y_d   = f_wrap(lfsr_q[13:8], c_SPAN_Y);
                    seg_addr_d = 6'd0;
                    len_d      = w_len;
                    state_d    = S_SCAN;
                end
                S_SCAN: begin
                    if (cmp_vld_q && w_match) begin
                        state_d = S_GEN;
                    end else if (cmp_vld_q && cmp_last_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        // Address on seg_addr this cycle is being read; its
                        // data is compared next cycle. Hold at the last index.
                        cmp_vld_d  = 1'b1;
                        cmp_last_d = w_last_issue;
                        if (!w_last_issue) seg_addr_d = seg_addr_q + 6'd1;
                    end
                end
                S_COMMIT: begin
                    apple_x_d     = cand_x_q;
                    apple_y_d     = cand_y_q;
                    apple_valid_d = 1'b1;
                    state_d       = S_PLAY;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign seg_addr_o    = seg_addr_q;
    assign apple_x_o     = apple_x_q;
    assign apple_y_o     = apple_y_q;
    assign apple_valid_o = apple_valid_q;
    assign apple_eaten_o = eaten_q;
    assign score_o       = score_q;
    assign busy_o        = (state_q == S_GEN) || (state_q == S_SCAN) || (state_q == S_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_apple_spawn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apple_spawn_ctrl
//  Purpose  : Self-checking bench for apple_spawn_ctrl. A transaction-level
//             model predicts each respawn (candidate sequence, retries and
//             commit cycle) from the LFSR sequence and the body contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apple_spawn_ctrl;

    localparam int SPAN_X = 38;
    localparam int SPAN_Y = 28;
    localparam int PERIOD = 65535;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [5:0] head_x, head_y;
    logic [6:0] snake_len;
    logic [5:0] seg_addr, seg_x, seg_y;
    logic [5:0] apple_x, apple_y;
    logic       apple_valid, apple_eaten, busy;
    logic [7:0] score;

    always #10 clk = ~clk;

    apple_spawn_ctrl dut (
        .clk_50MHz    (clk),
        .rst_n        (rst_n),
        .mode_i       (mode),
        .head_x_i     (head_x),
        .head_y_i     (head_y),
        .snake_len_i  (snake_len),
        .seg_addr_o   (seg_addr),
        .seg_x_i      (seg_x),
        .seg_y_i      (seg_y),
        .apple_x_o    (apple_x),
        .apple_y_o    (apple_y),
        .apple_valid_o(apple_valid),
        .apple_eaten_o(apple_eaten),
        .busy_o       (busy),
        .score_o      (score)
    );

    // Body RAM with one cycle of read latency.
    logic [5:0] body_x [0:63];
    logic [5:0] body_y [0:63];
    always @(posedge clk) begin
        seg_x <= body_x[seg_addr];
        seg_y <= body_y[seg_addr];
    end

    // Clock edges since reset release; the LFSR value during a cycle is
    // lfsr_tab[ncyc % PERIOD].
    int ncyc;
    always @(posedge clk) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    logic [15:0] lfsr_tab [0:PERIOD-1];

    int n_cmp = 0;
    int n_bad = 0;
    int m_score;
    logic [5:0] m_ax, m_ay;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void cand_of(input int n, output logic [5:0] cx, output logic [5:0] cy);
        logic [15:0] v;
        v  = lfsr_tab[n % PERIOD];
        cx = 6'((int'(v[5:0]) % SPAN_X) + 1);
        cy = 6'((int'(v[13:8]) % SPAN_Y) + 1);
    endfunction

    // g0: cycle number of the first GEN. Returns the committed cell and the
    // cycle number in which the new apple becomes visible.
    function automatic void predict(input int g0, input int len, output logic [5:0] ex,
                                    output logic [5:0] ey, output int vis);
        int g;
        int hit_k;
        g   = g0;
        vis = -1;
        ex  = 6'd0;
        ey  = 6'd0;
        for (int tries = 0; tries < 1000; tries++) begin
            cand_of(g, ex, ey);
            hit_k = -1;
            for (int k = 0; k < len; k++) begin
                if (hit_k < 0 && body_x[k] == ex && body_y[k] == ey) hit_k = k;
            end
            if (hit_k < 0) begin
                vis = g + len + 3;
                return;
            end
            g = g + 3 + hit_k;
        end
    endfunction

    task automatic rand_body(input int len);
        for (int k = 0; k < len; k++) begin
            body_x[k] = 6'($urandom_range(1, SPAN_X));
            body_y[k] = 6'($urandom_range(1, SPAN_Y));
        end
    endtask

    // One eat and respawn. force_idx >= 0 plants the first candidate on
    // that body index so the scan must retry.
    task automatic do_eat(input int len_in, input int force_idx, output int lat, output int exp_lat);
        int n0, vis, len, waited;
        logic [5:0] ex, ey, fx, fy;
        len = (len_in == 0) ? 1 : len_in;
        @(negedge clk);
        snake_len = 7'(len_in);
        n0 = ncyc;
        if (force_idx >= 0) begin
            cand_of(n0 + 1, fx, fy);
            body_x[force_idx] = fx;
            body_y[force_idx] = fy;
        end
        head_x = m_ax;
        head_y = m_ay;
        predict(n0 + 1, len, ex, ey, vis);
        exp_lat = vis - n0;
        if (m_score < 255) m_score++;
        @(negedge clk);
        chk("eaten_t1", apple_eaten, 1);
        chk("valid_t1", apple_valid, 0);
        chk("busy_t1", busy, 1);
        chk("score", score, m_score);
        head_x = 6'd0;
        head_y = 6'd0;
        waited = 0;
        while (apple_valid !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
            if (apple_valid !== 1'b1) begin
                chk("busy_wait", busy, 1);
                chk("eaten_once", apple_eaten, 0);
            end
        end
        lat = ncyc - n0;
        chk("latency", lat, exp_lat);
        chk("apple_x", apple_x, ex);
        chk("apple_y", apple_y, ey);
        chk("valid_end", apple_valid, 1);
        chk("busy_end", busy, 0);
        chk("x_range", (apple_x >= 6'd1 && apple_x <= 6'(SPAN_X)), 1);
        chk("y_range", (apple_y >= 6'd1 && apple_y <= 6'(SPAN_Y)), 1);
        m_ax = ex;
        m_ay = ey;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int lat, elat, n0;
        v = 16'hACE1;
        for (int i = 0; i < PERIOD; i++) begin
            lfsr_tab[i] = v;
            v = {v[14:0], ^(v & 16'hB400)};
        end
        for (int k = 0; k < 64; k++) begin
            body_x[k] = 6'd0;
            body_y[k] = 6'd0;
        end
        body_x[0] = 6'd10; body_y[0] = 6'd10;
        body_x[1] = 6'd9;  body_y[1] = 6'd10;
        body_x[2] = 6'd8;  body_y[2] = 6'd10;
        rst_n = 1'b0; mode = 2'd1; head_x = 6'd0; head_y = 6'd0; snake_len = 7'd3;
        m_score = 0; m_ax = 6'd25; m_ay = 6'd15;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_apple_x", apple_x, 25);
        chk("rst_apple_y", apple_y, 15);
        chk("rst_valid", apple_valid, 1);
        chk("rst_score", score, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eaten", apple_eaten, 0);
        chk("rst_seg_addr", seg_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Eat with no conflict, L=3
        do_eat(3, -1, lat, elat);
        if (elat == 7) chk("lat_clean", lat, 7);

        // Forced retry on segment 2
        body_x[0] = 6'd10; body_y[0] = 6'd10;
        body_x[1] = 6'd9;  body_y[1] = 6'd10;
        do_eat(3, 2, lat, elat);
        if (elat == 12) chk("lat_retry", lat, 12);

        // Random lengths and bodies, with occasional forced retries
        for (int i = 0; i < 150; i++) begin
            int len, fi;
            len = $urandom_range(0, 10);
            rand_body((len == 0) ? 1 : len);
            fi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ((len == 0) ? 1 : len) - 1) : -1;
            do_eat(len, fi, lat, elat);
        end

        // Mode abort during the second scan cycle
        body_x[0] = 6'd10; body_y[0] = 6'd10;
        body_x[1] = 6'd9;  body_y[1] = 6'd10;
        body_x[2] = 6'd8;  body_y[2] = 6'd10;
        @(negedge clk);
        snake_len = 7'd3;
        head_x = m_ax;
        head_y = m_ay;
        n0 = ncyc;
        if (m_score < 255) m_score++;
        @(negedge clk);
        chk("abort_eaten", apple_eaten, 1);
        head_x = 6'd0;
        head_y = 6'd0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_scan", busy, 1);
        chk("abort_cycle", ncyc - n0, 3);
        mode = 2'd2;
        @(negedge clk);
        chk("abort_x", apple_x, 25);
        chk("abort_y", apple_y, 15);
        chk("abort_valid", apple_valid, 1);
        chk("abort_busy", busy, 0);
        chk("abort_eaten_once", apple_eaten, 0);
        chk("abort_score", score, m_score);
        repeat (3) @(negedge clk);
        chk("gameover_score_hold", score, m_score);
        mode = 2'd0;
        @(negedge clk);
        chk("menu_score_clear", score, 0);
        m_score = 0;
        mode = 2'd1;
        @(negedge clk);
        m_ax = 6'd25;
        m_ay = 6'd15;

        // Bounds and saturation: 2000 eats with L=1
        for (int i = 0; i < 2000; i++) begin
            rand_body(1);
            do_eat(1, ($urandom_range(0, 7) == 0) ? 0 : -1, lat, elat);
            if (i == 259) chk("score_sat_260", score, 255);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
